// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit adder/subtractor among NREQ requesters
// and returns an ID-tagged, flag-qualified result over a valid/ready response channel.

module adder_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] answer,
  output logic             carry,
  output logic             ovf
);
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;

  // Subtract is A + ~B + 1; overflow when like-signed operands yield a differently signed result.
  always_comb begin
    b_eff_s = s ? ~b : b;
    sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, s};
    answer  = sum_s[WIDTH-1:0];
    carry   = sum_s[WIDTH];
    ovf     = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

module addsub_arbiter #(
  parameter int WIDTH = 6,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  input  logic [NREQ-1:0]       op_sub,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_ovf
);
  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state_r, state_s;
  logic             busy_r;
  logic [1:0]       ptr_r, win_s;
  logic             found_s;
  logic [NREQ-1:0]  gnt_s;
  logic [WIDTH-1:0] a_r, b_r;
  logic             sub_r;
  logic [1:0]       id_r;
  logic [WIDTH-1:0] answer_s;
  logic             carry_s, ovf_s;
  logic [WIDTH-1:0] result_r;
  logic             carry_r, ovf_r, valid_r;
  logic [1:0]       rsp_id_r;

  adder_subtractor #(.WIDTH(WIDTH)) u_addsub (
    .a      (a_r),
    .b      (b_r),
    .s      (sub_r),
    .answer (answer_s),
    .carry  (carry_s),
    .ovf    (ovf_s)
  );

  // Winner search starting at ptr and wrapping modulo NREQ; the first pending requester wins.
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    win_s   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_r) + k) % NREQ;
      if (!found_s && req[idx[IW-1:0]]) begin
        found_s = 1'b1;
        win_s   = 2'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // State register; busy is registered alongside so it tracks the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Next-state logic: arbitrate only in IDLE, one EXEC cycle, hold RESP until accepted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) state_s = EXEC;
        else         state_s = IDLE;
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Mealy grant to the winner, issued only while idle.
  always_comb begin
    if ((state_r == IDLE) && found_s) begin
      gnt_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
    end else begin
      gnt_s = {NREQ{1'b0}};
    end
  end

  // Operand capture on grant; the pointer moves past the winner so it drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 2'd0;
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      sub_r <= 1'b0;
      id_r  <= 2'd0;
    end else if ((state_r == IDLE) && found_s) begin
      a_r   <= op_a[win_s*WIDTH +: WIDTH];
      b_r   <= op_b[win_s*WIDTH +: WIDTH];
      sub_r <= op_sub[win_s];
      id_r  <= win_s;
      ptr_r <= (win_s == 2'(NREQ-1)) ? 2'd0 : win_s + 2'd1;
    end
  end

  // Response registers: loaded from the shared unit in EXEC, held until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      rsp_id_r <= 2'd0;
      valid_r  <= 1'b0;
    end else if (state_r == EXEC) begin
      result_r <= answer_s;
      carry_r  <= carry_s;
      ovf_r    <= ovf_s;
      rsp_id_r <= id_r;
      valid_r  <= 1'b1;
    end else if ((state_r == RESP) && rsp_ready) begin
      valid_r  <= 1'b0;
    end
  end

  assign gnt        = gnt_s;
  assign busy       = busy_r;
  assign rsp_valid  = valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = result_r;
  assign rsp_carry  = carry_r;
  assign rsp_ovf    = ovf_r;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: randomized requesters, arithmetic reference model,
// per-cycle grant/busy checks in the driver and a decoupled response monitor.
module tb_addsub_arbiter;
  localparam int WIDTH = 6;
  localparam int NREQ  = 4;
  localparam int MOD   = 1 << WIDTH;
  localparam int HALF  = MOD / 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] op_a = '0, op_b = '0;
  logic [NREQ-1:0]       op_sub = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy, rsp_valid, rsp_carry, rsp_ovf;
  logic                  rsp_ready = 1'b1;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_result;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf)
  );

  typedef struct packed {
    logic [1:0]       id;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0, n_err = 0;
  int   m_phase = 0;   // 0 idle, 1 executing, 2 response pending
  int   m_ptr = 0;
  int   last_win = -1;
  bit   keep_mode = 1'b0;
  logic [WIDTH-1:0] pa[NREQ], pb[NREQ];
  logic ps[NREQ], preq[NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from plain integer math: unsigned for result/carry, signed for overflow.
  function automatic rsp_t ref_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic s);
    rsp_t r;
    int ua, ub, sa, sb, u, sv;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= HALF) ? ua - MOD : ua;
    sb = (ub >= HALF) ? ub - MOD : ub;
    if (s) begin
      u = ua - ub; sv = sa - sb; r.c = (ua >= ub);
    end else begin
      u = ua + ub; sv = sa + sb; r.c = (u >= MOD);
    end
    r.res = WIDTH'((u + MOD) % MOD);
    r.v   = (sv >= HALF) || (sv < -HALF);
    r.id  = 2'(id);
    return r;
  endfunction

  task automatic new_ops(input int i);
    pa[i] = WIDTH'($urandom);
    pb[i] = WIDTH'($urandom);
    ps[i] = 1'($urandom);
    preq[i] = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = preq[i];
      op_sub[i] = ps[i];
      op_a[i*WIDTH +: WIDTH] = pa[i];
      op_b[i*WIDTH +: WIDTH] = pb[i];
    end
  endtask

  function automatic bit any_req();
    bit r;
    r = 1'b0;
    for (int i = 0; i < NREQ; i++) r = r | preq[i];
    return r;
  endfunction

  // One clock: predict the grant from the model, compare, advance the model, apply requester protocol.
  task automatic step();
    logic [NREQ-1:0] eg;
    int w, j;
    drive();
    #1;
    eg = '0;
    w = -1;
    if (m_phase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (w < 0 && preq[j]) w = j;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    last_win = w;
    if (w >= 0) begin
      exp_q.push_back(ref_op(w, pa[w], pb[w], ps[w]));
      m_ptr = (w + 1) % NREQ;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && rsp_ready) begin
      m_phase = 0;
    end
    @(posedge clk);
    @(negedge clk);
    if (w >= 0) begin
      if (keep_mode) new_ops(w);
      else preq[w] = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_phase != 0 || any_req()) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(m_phase != 0 || any_req()), 32'd0);
  endtask

  // Asynchronous reset: outputs must clear without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_carry", 32'(rsp_carry), 32'd0);
    chk("rst_ovf", 32'(rsp_ovf), 32'd0);
    m_phase = 0;
    m_ptr = 0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) preq[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Response monitor: compares the queue head whenever a result is presented; pops on handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got id %0d result %0h with nothing expected", rsp_id, rsp_result);
        end else begin
          e = exp_q[0];
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_result", 32'(rsp_result), 32'(e.res));
          chk("rsp_carry", 32'(rsp_carry), 32'(e.c));
          chk("rsp_ovf", 32'(rsp_ovf), 32'(e.v));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int va[5] = '{15, 15, 31, 63, 0};
    int vb[5] = '{33, 33, 1, 1, 1};
    bit vs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int n;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = '0; pb[i] = '0; ps[i] = 1'b0; preq[i] = 1'b0;
    end
    @(negedge clk);
    do_reset();
    step();
    step();

    // Directed arithmetic cases through requester 0.
    rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      pa[0] = WIDTH'(va[t]);
      pb[0] = WIDTH'(vb[t]);
      ps[0] = vs[t];
      preq[0] = 1'b1;
      drain(20);
    end

    // Round robin from ptr=0 with all requesters continuously requesting.
    do_reset();
    for (int i = 0; i < NREQ; i++) new_ops(i);
    keep_mode = 1'b1;
    repeat (15) step();
    keep_mode = 1'b0;
    drain(40);

    // Backpressure with requester 2 pending behind a stalled response.
    rsp_ready = 1'b0;
    new_ops(0);
    n = 0;
    do begin step(); n++; end while (last_win != 0 && n < 10);
    new_ops(2);
    step();
    repeat (5) step();
    rsp_ready = 1'b1;
    drain(20);

    // Wrap: ptr now 3, requesters 0 and 2 pending.
    new_ops(0);
    new_ops(2);
    drain(20);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!preq[i] && $urandom_range(0, 2) == 0) new_ops(i);
      rsp_ready = ($urandom_range(0, 3) != 0);
      keep_mode = 1'(($urandom_range(0, 1)));
      step();
    end
    keep_mode = 1'b0;
    rsp_ready = 1'b1;
    drain(100);

    // Reset while a result is held in RESP.
    rsp_ready = 1'b0;
    new_ops(1);
    n = 0;
    while (m_phase != 2 && n < 10) begin step(); n++; end
    step();
    #3;
    do_reset();
    rsp_ready = 1'b1;
    repeat (3) step();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
